// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - loadable bidirectional modulo-2^WIDTH counter with hold
module up_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dir,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_step;

  // Wrap-around falls out of the fixed-width add/subtract.
  assign count_step = dir ? (count_q + ONE) : (count_q - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (ld) begin
      count_q <= ld_val;
    end else if (en) begin
      count_q <= count_step;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - directed self-checking bench for up_down_counter
module tb_up_down_counter;

  logic       clk;
  logic       rst;
  logic       ld;
  logic [3:0] ld_val;
  logic       dir;
  logic       en;
  logic [3:0] count;

  int n_cmp;
  int n_bad;

  up_down_counter #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ld     (ld),
    .ld_val (ld_val),
    .dir    (dir),
    .en     (en),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs across one rising edge, then check count just after it.
  task automatic step(input logic r, input logic l, input logic [3:0] v,
                      input logic d, input logic e,
                      input logic [3:0] exp, input string tag);
    rst = r; ld = l; ld_val = v; dir = d; en = e;
    @(posedge clk);
    #1;
    n_cmp++;
    assert (count === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, count, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0; ld = 1'b0; ld_val = 4'd0; dir = 1'b1; en = 1'b0;
    @(negedge clk);

    // Reset held with counting requested
    step(1, 0, 4'd0, 1, 1, 4'd0, "rst_edge1");
    step(1, 0, 4'd0, 1, 1, 4'd0, "rst_edge2");
    step(0, 0, 4'd0, 1, 1, 4'd1, "post_rst_1");
    step(0, 0, 4'd0, 1, 1, 4'd2, "post_rst_2");
    step(0, 0, 4'd0, 1, 1, 4'd3, "post_rst_3");

    // Up-count from 0 through wrap
    step(0, 1, 4'd0, 1, 1, 4'd0, "load_0");
    for (int i = 1; i <= 15; i++) step(0, 0, 4'd0, 1, 1, 4'(i), "up_count");
    step(0, 0, 4'd0, 1, 1, 4'd0, "up_wrap_f_to_0");
    step(0, 0, 4'd0, 1, 1, 4'd1, "up_after_wrap");

    // Hold with dir toggling
    step(0, 1, 4'd5, 1, 1, 4'd5, "load_5");
    for (int i = 0; i < 7; i++) step(0, 0, 4'd0, 1'(i), 0, 4'd5, "hold");

    // Down-count through wrap
    step(0, 1, 4'd2, 0, 0, 4'd2, "load_2");
    step(0, 0, 4'd0, 0, 1, 4'd1, "down_1");
    step(0, 0, 4'd0, 0, 1, 4'd0, "down_0");
    step(0, 0, 4'd0, 0, 1, 4'd15, "down_wrap_0_to_f");
    step(0, 0, 4'd0, 0, 1, 4'd14, "down_14");

    // Load beats enable
    step(0, 1, 4'b0101, 0, 1, 4'd5, "ld_over_en");
    step(0, 0, 4'd0, 0, 1, 4'd4, "down_after_ld_4");
    step(0, 0, 4'd0, 0, 1, 4'd3, "down_after_ld_3");
    step(0, 1, 4'b0101, 0, 0, 4'd5, "ld_no_en");
    step(0, 0, 4'd0, 0, 0, 4'd5, "hold_after_ld_1");
    step(0, 0, 4'd0, 1, 0, 4'd5, "hold_after_ld_2");

    // Reset beats load; held load keeps reloading
    step(1, 1, 4'd9, 1, 1, 4'd0, "rst_over_ld");
    step(0, 1, 4'd9, 1, 1, 4'd9, "ld_after_rst");
    step(0, 1, 4'd9, 1, 1, 4'd9, "ld_held");

    // Direction change takes effect immediately
    step(0, 0, 4'd0, 1, 1, 4'd10, "dir_up");
    step(0, 0, 4'd0, 0, 1, 4'd9, "dir_flip_down");

    // Reset mid-count, then resume
    step(1, 0, 4'd0, 0, 1, 4'd0, "rst_mid_count");
    step(0, 0, 4'd0, 1, 1, 4'd1, "resume_after_rst");
    step(0, 0, 4'd0, 0, 1, 4'd0, "down_to_0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
